// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Register offsets and defaults for the GPIO edge-interrupt
//               stage. Offsets are relative to BASE+OFFSET.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

    // Default debounce counter / threshold width
    localparam int GPIO_CNT_W = 8;

    // Write-side register offsets
    localparam logic [31:0] EN_CLR   = 32'h0000_0000;
    localparam logic [31:0] EN_SET   = 32'h0000_0004;
    localparam logic [31:0] RISE_CLR = 32'h0000_0008;
    localparam logic [31:0] RISE_SET = 32'h0000_000C;
    localparam logic [31:0] FALL_CLR = 32'h0000_0010;
    localparam logic [31:0] FALL_SET = 32'h0000_0014;
    localparam logic [31:0] PEND_W1C = 32'h0000_0018;
    localparam logic [31:0] THR      = 32'h0000_001C;

    // Read-side register offsets
    localparam logic [31:0] PEND_RD  = 32'h0000_0020;
    localparam logic [31:0] FILT_RD  = 32'h0000_0024;
    localparam logic [31:0] THR_RD   = 32'h0000_0028;
    localparam logic [31:0] EN_RD    = 32'h0000_002C;

endpackage
`default_nettype wire

// File: rtl/gpio_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : gpio_debounce_bit
// Description : One pin: two-flop synchroniser followed by a mismatch counter
//               that only accepts a new level after it has been seen for
//               thr+1 consecutive cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int CNT_W = GPIO_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_pin,
    input  logic [CNT_W-1:0] i_thr,
    output logic             o_filt
);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_filt;

    // Synchronise the raw pin and debounce it against the current threshold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_filt  <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt >= i_thr) begin
                // >= so a threshold lowered mid-count releases immediately
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/gpio_edge_irq.sv
`default_nettype none
// ============================================================================
// Module      : gpio_edge_irq
// Description : GPIO input conditioning and interrupt stage. Debounced pins
//               are edge-detected, edges latch into a pending register and
//               enabled pending bits raise a single level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_edge_irq
    import gpio_pkg::*;
#(
    parameter logic [31:0] BASE   = 32'h8003_0000,
    parameter logic [31:0] OFFSET = 32'h0000_0100,
    parameter int          B0_BW  = 8,
    parameter int          CNT_W  = GPIO_CNT_W
) (
    input  logic             clk,
    input  logic             c_sys_rst,
    input  logic [B0_BW-1:0] b0_data_in,
    input  logic             ic0_c_axi_mst_wr_valid,
    input  logic             ic0_c_axi_mst_rd_valid,
    input  logic [31:0]      ic0_axi_mst_wr_addr,
    input  logic [31:0]      ic0_axi_mst_wr_data,
    input  logic [31:0]      ic0_axi_mst_rd_addr,
    output logic             ic0_c_axi_slv_rd_ready_1,
    output logic [31:0]      ic0_axi_slv_rd_data_1,
    output logic             irq_o
);

    localparam logic [31:0] c_base = BASE + OFFSET;

    logic [B0_BW-1:0] r_en;
    logic [B0_BW-1:0] r_rise_en;
    logic [B0_BW-1:0] r_fall_en;
    logic [B0_BW-1:0] r_pend;
    logic [B0_BW-1:0] r_filt_d;
    logic [CNT_W-1:0] r_thr;
    logic             r_irq;

    logic [B0_BW-1:0] w_filt;
    logic [B0_BW-1:0] w_rise;
    logic [B0_BW-1:0] w_fall;
    logic [B0_BW-1:0] w_wdata;
    logic [B0_BW-1:0] w_w1c;
    logic             w_unused_wdata;

    // Only the low bits of write data reach the pin-wide registers
    assign w_wdata        = ic0_axi_mst_wr_data[B0_BW-1:0];
    assign w_unused_wdata = ^ic0_axi_mst_wr_data;

    // One debouncer per pin
    for (genvar gi = 0; gi < B0_BW; gi++) begin : g_bit
        gpio_debounce_bit #(
            .CNT_W (CNT_W)
        ) u_debounce (
            .clk    (clk),
            .rst    (c_sys_rst),
            .i_pin  (b0_data_in[gi]),
            .i_thr  (r_thr),
            .o_filt (w_filt[gi])
        );
    end

    assign w_rise = w_filt & ~r_filt_d;
    assign w_fall = ~w_filt & r_filt_d;

    // Write-one-to-clear mask for the pending register
    always_comb begin
        w_w1c = '0;
        if (ic0_c_axi_mst_wr_valid && (ic0_axi_mst_wr_addr == c_base + PEND_W1C)) begin
            w_w1c = w_wdata;
        end
    end

    // Register file, edge history, pending capture and interrupt output
    always_ff @(posedge clk) begin
        if (c_sys_rst) begin
            r_en      <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_pend    <= '0;
            r_filt_d  <= '0;
            r_thr     <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (ic0_c_axi_mst_wr_valid) begin
                case (ic0_axi_mst_wr_addr)
                    c_base + EN_CLR:   r_en      <= r_en & ~w_wdata;
                    c_base + EN_SET:   r_en      <= r_en | w_wdata;
                    c_base + RISE_CLR: r_rise_en <= r_rise_en & ~w_wdata;
                    c_base + RISE_SET: r_rise_en <= r_rise_en | w_wdata;
                    c_base + FALL_CLR: r_fall_en <= r_fall_en & ~w_wdata;
                    c_base + FALL_SET: r_fall_en <= r_fall_en | w_wdata;
                    c_base + THR:      r_thr     <= ic0_axi_mst_wr_data[CNT_W-1:0];
                    default: ;
                endcase
            end
            r_filt_d <= w_filt;
            // New edges are OR-ed in after the clear, so a same-cycle set wins
            r_pend   <= (r_pend & ~w_w1c) | (w_rise & r_rise_en) | (w_fall & r_fall_en);
            r_irq    <= |(r_pend & r_en);
        end
    end

    assign irq_o = r_irq;

    // Zero-wait-state read decode
    always_comb begin
        ic0_c_axi_slv_rd_ready_1 = 1'b0;
        ic0_axi_slv_rd_data_1    = 'x;
        if (ic0_c_axi_mst_rd_valid) begin
            case (ic0_axi_mst_rd_addr)
                c_base + PEND_RD: begin
                    ic0_c_axi_slv_rd_ready_1 = 1'b1;
                    ic0_axi_slv_rd_data_1    = 32'(r_pend);
                end
                c_base + FILT_RD: begin
                    ic0_c_axi_slv_rd_ready_1 = 1'b1;
                    ic0_axi_slv_rd_data_1    = 32'(w_filt);
                end
                c_base + THR_RD: begin
                    ic0_c_axi_slv_rd_ready_1 = 1'b1;
                    ic0_axi_slv_rd_data_1    = 32'(r_thr);
                end
                c_base + EN_RD: begin
                    ic0_c_axi_slv_rd_ready_1 = 1'b1;
                    ic0_axi_slv_rd_data_1    = 32'(r_en);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
